alu_pipe: RTL
=============

Name: alu_pipe

Overview:
Parametrised, pipelined successor to the combinational 16-bit signed ALU with S/ZR/CY/P/V flags. It adds:
- a valid/ready handshake on input and output, with a 2-stage registered datapath;
- saturating add/subtract;
- an internal accumulator op, used for membrane-potential integration in the spiking-neuron datapath.

It sits between the synapse-weight fetch logic and the neuron state update.

Parameters:
WIDTH, 16, operand/result width in bits (two's complement), minimum 4
SAT_EN, 1, 1 = ADDS/SUBS/ACC saturate; 0 = those ops wrap like ADD/SUB

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand transaction present
in_ready  output  1  block accepts transaction this cycle
op  input  3  operation select, sampled with operands
acc_clr  input  1  for op ACC only: replace accumulator instead of adding
x  input  WIDTH  operand X, signed
y  input  WIDTH  operand Y, signed
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
z  output  WIDTH  result, signed
s  output  1  sign flag
zr  output  1  zero flag
cy  output  1  carry/borrow flag
p  output  1  even-parity flag
v  output  1  signed overflow / saturation-occurred flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: stage-1 valid 0; out_valid 0; z, s, zr, cy, p, v all 0; accumulator 0.
- rst asserted mid-operation discards all in-flight transactions; no result is emitted for them.
- Advance enable: en = !out_valid || out_ready (combinational). in_ready = en.
- On en:
  - stage 1 loads {in_valid, op, acc_clr, x, y};
  - stage 2 (the output registers) loads the computed result of stage 1, with out_valid <= stage-1 valid.
- When en is 0, all registers hold. z and flags stay stable while out_valid && !out_ready.
- Latency: 2 cycles from an accepted input to out_valid, with no stall. Throughput is 1 per cycle. Results emerge in order.
- Bubbles, i.e. in_valid=0 at an accepted slot, propagate as out_valid=0.
- Ops (with N = WIDTH; true result computed at N+1 bits):
  - 000 ADD: z = x+y, wrap.
  - 001 SUB: z = x-y, wrap.
  - 010 ADDS: x+y, saturating.
  - 011 SUBS: x-y, saturating.
  - 100 AND; 101 OR; 110 XOR: bitwise.
  - 111 ACC: if acc_clr, acc_next = x; else acc_next = acc+x, saturating if SAT_EN=1, otherwise wrap. z = acc_next. The accumulator updates only when the ACC transaction enters stage 2, so back-to-back ACC ops chain correctly.
- Saturation: positive overflow gives 2^(N-1)-1; negative overflow gives -2^(N-1). With SAT_EN=0, ADDS/SUBS are identical to ADD/SUB.
- Flags, all computed on the final z and registered with it:
  - s = z[N-1].
  - zr = (z == 0).
  - p = 1 when z has an even number of ones.
  - cy for ADD/ADDS/ACC (non-clr): unsigned carry out of bit N-1.
  - cy for SUB/SUBS: borrow, i.e. 1 when x < y unsigned.
  - cy = 0 for logic ops and for ACC with acc_clr.
  - v = 1 when the true signed result overflows N bits, including when saturation was applied. v = 0 for logic ops and for ACC with acc_clr.
- Simultaneous events: rst has priority over any handshake. out_ready with in_valid in the same cycle gives a simultaneous retire and accept, with no bubble.

Test Plan:
- Reset, then ADD x=-5, y=-10 with out_ready=1 → 2 cycles later: z=-15 (0xFFF1), s=1, zr=0, cy=1, p=0, v=0.
- ADD 32767+1 → z=-32768, v=1, cy=0, s=1. Then ADDS 32767+1 → z=32767, v=1, s=0, p=0. Repeat with SAT_EN=0 → ADDS gives -32768.
- SUB 5-5 → z=0, zr=1, cy=0, p=1. SUB 3-5 → z=-2, cy=1, s=1, p=0.
- XOR 0x00FF^0x0F0F → z=0x0FF0, p=1, cy=0, v=0. ACC clr x=100, then ACC x=-30, then ACC x=-70 (back-to-back) → z=100, 70, 0 with zr=1 on the last.
- Backpressure: stream 4 ADDs, drop out_ready for 3 cycles while out_valid=1 → in_ready=0, z/flags held. Release → all 4 results in order, none lost or duplicated.
- Assert rst with 2 transactions in flight → next cycle out_valid=0, then an ACC x=7 (no clr) → z=7, confirming the accumulator was cleared.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with valid/ready handshake,
// saturating add/sub and an integrating accumulator op.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             s,
    output logic             zr,
    output logic             cy,
    output logic             p,
    output logic             v
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADDS = 3'b010,
        OP_SUBS = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_ACC  = 3'b111
    } op_t;

    typedef struct packed {
        logic             valid;
        op_t              op;
        logic             clr;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } s1_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    s1_t              s1;
    logic [WIDTH-1:0] acc;
    logic             en;

    // Unsigned sums give carry/borrow, sign-extended sums give overflow
    logic [WIDTH:0]   add_u;
    logic [WIDTH:0]   sub_u;
    logic [WIDTH:0]   acc_u;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   acc_s;
    logic             add_ov;
    logic             sub_ov;
    logic             acc_ov;

    logic [WIDTH-1:0] r_z;
    logic             r_cy;
    logic             r_v;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign add_u = {1'b0, s1.x} + {1'b0, s1.y};
    assign sub_u = {1'b0, s1.x} - {1'b0, s1.y};
    assign acc_u = {1'b0, acc} + {1'b0, s1.x};

    assign add_s = {s1.x[WIDTH-1], s1.x} + {s1.y[WIDTH-1], s1.y};
    assign sub_s = {s1.x[WIDTH-1], s1.x} - {s1.y[WIDTH-1], s1.y};
    assign acc_s = {acc[WIDTH-1], acc} + {s1.x[WIDTH-1], s1.x};

    // Overflow when the extra sign bit disagrees with the result MSB
    assign add_ov = add_s[WIDTH] ^ add_s[WIDTH-1];
    assign sub_ov = sub_s[WIDTH] ^ sub_s[WIDTH-1];
    assign acc_ov = acc_s[WIDTH] ^ acc_s[WIDTH-1];

    // Clamp toward the sign of the true (N+1)-bit result
    function automatic logic [WIDTH-1:0] clip(
        input logic [WIDTH:0] t,
        input logic           ovf,
        input logic           sat
    );
        if (sat && ovf) begin
            return t[WIDTH] ? MAX_NEG : MAX_POS;
        end
        return t[WIDTH-1:0];
    endfunction

    // Result and carry/overflow selection for the op held in stage 1
    always_comb begin
        r_z  = '0;
        r_cy = 1'b0;
        r_v  = 1'b0;
        unique case (s1.op)
            OP_ADD: begin
                r_z  = add_s[WIDTH-1:0];
                r_cy = add_u[WIDTH];
                r_v  = add_ov;
            end
            OP_SUB: begin
                r_z  = sub_s[WIDTH-1:0];
                r_cy = sub_u[WIDTH];
                r_v  = sub_ov;
            end
            OP_ADDS: begin
                r_z  = clip(add_s, add_ov, SAT_EN);
                r_cy = add_u[WIDTH];
                r_v  = add_ov;
            end
            OP_SUBS: begin
                r_z  = clip(sub_s, sub_ov, SAT_EN);
                r_cy = sub_u[WIDTH];
                r_v  = sub_ov;
            end
            OP_AND: r_z = s1.x & s1.y;
            OP_OR:  r_z = s1.x | s1.y;
            OP_XOR: r_z = s1.x ^ s1.y;
            OP_ACC: begin
                if (s1.clr) begin
                    r_z = s1.x;
                end else begin
                    r_z  = clip(acc_s, acc_ov, SAT_EN);
                    r_cy = acc_u[WIDTH];
                    r_v  = acc_ov;
                end
            end
        endcase
    end

    // Stage 1: capture operands when the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else if (en) begin
            s1 <= '{in_valid, op_t'(op), acc_clr, x, y};
        end
    end

    // Stage 2: registered result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            z         <= '0;
            s         <= 1'b0;
            zr        <= 1'b0;
            cy        <= 1'b0;
            p         <= 1'b0;
            v         <= 1'b0;
        end else if (en) begin
            out_valid <= s1.valid;
            z         <= r_z;
            s         <= r_z[WIDTH-1];
            zr        <= (r_z == '0);
            cy        <= r_cy;
            p         <= ~^r_z;
            v         <= r_v;
        end
    end

    // Accumulator commits as the ACC result enters stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en && s1.valid && (s1.op == OP_ACC)) begin
            acc <= r_z;
        end
    end

endmodule
